// File: rtl/snoop_pkg.sv
// Shared types and constants for the snoop initiator slice.
package snoop_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    INVAL,
    DONE
  } snoop_state_e;

  // Cache line status encoding
  localparam logic [1:0] STATUS_I = 2'b00;
  localparam logic [1:0] STATUS_S = 2'b01;
  localparam logic [1:0] STATUS_E = 2'b10;
  localparam logic [1:0] STATUS_M = 2'b11;

  localparam int unsigned SNOOP_TIMEOUT_DEFAULT = 16;

  // PHIT alone cannot tell S from E, so a clean hit is recorded as S.
  function automatic logic [1:0] snoop_status(input logic phit, input logic phitm);
    if (phitm) return STATUS_M;
    if (phit)  return STATUS_S;
    return STATUS_I;
  endfunction

endpackage

// File: rtl/snoop_initiator_if.sv
// Request/inquiry/write-back/result bundle between the arbiter side, the
// snoop initiator (master) and the cache responder side (slave).
interface snoop_initiator_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_rw;
  logic              SINT;
  logic              SLCK;
  logic              RW;
  logic [ADDR_W-1:0] SADDR;
  logic              snoop;
  logic              PHIT;
  logic              PHITM;
  logic              PINV;
  logic              wb_req;
  logic              wb_done;
  logic              rsp_valid;
  logic              rsp_hit;
  logic              rsp_hitm;
  logic              rsp_timeout;

  modport master (
    input  req_valid, req_addr, req_rw, snoop, PHIT, PHITM, PINV, wb_done,
    output req_ready, SINT, SLCK, RW, SADDR, wb_req,
           rsp_valid, rsp_hit, rsp_hitm, rsp_timeout
  );

  modport slave (
    output req_valid, req_addr, req_rw, snoop, PHIT, PHITM, PINV, wb_done,
    input  req_ready, SINT, SLCK, RW, SADDR, wb_req,
           rsp_valid, rsp_hit, rsp_hitm, rsp_timeout
  );
endinterface

// File: rtl/snoop_timeout_ctr.sv
// Handshake watchdog: cleared on state entry, counts while enabled, and
// flags expiry once the count reaches TIMEOUT-1.
module snoop_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  // Next count: clear wins, then hold at LAST
  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (en && (count_q != LAST))
      count_d = count_q + 1'b1;
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign expire = en && (count_q == LAST);
endmodule

// File: rtl/snoop_initiator.sv
// Bus-side snoop inquiry sequencer: lookup, optional write-back, optional
// invalidate, then a single-cycle result record.
// Optional feature macro: SNOOP_STATS_EN adds saturating hit/hitm/timeout counters.
module snoop_initiator
  import snoop_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = SNOOP_TIMEOUT_DEFAULT
) (
  input  logic        SCLK,
  input  logic        SRST,
  snoop_initiator_if.master bus
`ifdef SNOOP_STATS_EN
  ,
  output logic [15:0] stat_hit,
  output logic [15:0] stat_hitm,
  output logic [15:0] stat_tmo
`endif
);

  snoop_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [1:0]        status_q, status_d;
  logic              tmo_q, tmo_d;
  logic              ready_q, ready_d;
  logic              pinv_seen_q, pinv_seen_d;
  logic              active, timer_clr, timer_exp;
  logic              rsp_valid, rsp_hit, rsp_hitm, rsp_timeout;

  assign active    = (state_q == LOOKUP) || (state_q == WRITEBACK) || (state_q == INVAL);
  assign timer_clr = (state_d != state_q);

  snoop_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (SCLK),
    .rst    (SRST),
    .clr    (timer_clr),
    .en     (active),
    .expire (timer_exp)
  );

  // Next-state and capture logic; a real handshake beats a same-cycle expiry
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    status_d    = status_q;
    tmo_d       = tmo_q;
    pinv_seen_d = pinv_seen_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          addr_d   = bus.req_addr;
          rw_d     = bus.req_rw;
          status_d = STATUS_I;
          tmo_d    = 1'b0;
          state_d  = LOOKUP;
        end
      end
      LOOKUP: begin
        if (bus.snoop) begin
          status_d = snoop_status(bus.PHIT, bus.PHITM);
          if (bus.PHITM)  state_d = WRITEBACK;
          else if (!rw_q) state_d = INVAL;
          else            state_d = DONE;
        end else if (timer_exp) begin
          tmo_d   = 1'b1;
          state_d = DONE;
        end
      end
      WRITEBACK: begin
        if (bus.wb_done) begin
          state_d = rw_q ? DONE : INVAL;
        end else if (timer_exp) begin
          tmo_d   = 1'b1;
          state_d = DONE;
        end
      end
      INVAL: begin
        if (!bus.PINV) pinv_seen_d = 1'b1;
        if (bus.PINV && !bus.snoop && pinv_seen_q) begin
          state_d = DONE;
        end else if (timer_exp) begin
          tmo_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A PINV still high from the previous operation must drop before it counts
    if ((state_d == INVAL) && (state_q != INVAL))
      pinv_seen_d = !bus.PINV;
    ready_d = (state_d == IDLE);
  end

  // State and capture registers
  always_ff @(posedge SCLK or posedge SRST) begin
    if (SRST) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rw_q        <= 1'b1;
      status_q    <= STATUS_I;
      tmo_q       <= 1'b0;
      ready_q     <= 1'b0;
      pinv_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      status_q    <= status_d;
      tmo_q       <= tmo_d;
      ready_q     <= ready_d;
      pinv_seen_q <= pinv_seen_d;
    end
  end

  assign rsp_valid   = (state_q == DONE);
  assign rsp_hit     = rsp_valid && (status_q != STATUS_I);
  assign rsp_hitm    = rsp_valid && (status_q == STATUS_M);
  assign rsp_timeout = rsp_valid && tmo_q;

  assign bus.req_ready   = ready_q;
  assign bus.SINT        = !active;
  assign bus.SLCK        = (state_q == LOOKUP) || (state_q == WRITEBACK);
  assign bus.RW          = bus.SLCK ? rw_q : (state_q != INVAL);
  assign bus.SADDR       = addr_q;
  assign bus.wb_req      = (state_q == WRITEBACK);
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_hit     = rsp_hit;
  assign bus.rsp_hitm    = rsp_hitm;
  assign bus.rsp_timeout = rsp_timeout;

`ifdef SNOOP_STATS_EN
  logic [15:0] stat_hit_q, stat_hit_d;
  logic [15:0] stat_hitm_q, stat_hitm_d;
  logic [15:0] stat_tmo_q, stat_tmo_d;

  // Saturating per-flag counters, bumped on the result cycle
  always_comb begin
    stat_hit_d  = stat_hit_q;
    stat_hitm_d = stat_hitm_q;
    stat_tmo_d  = stat_tmo_q;
    if (rsp_hit     && (stat_hit_q  != '1)) stat_hit_d  = stat_hit_q  + 16'd1;
    if (rsp_hitm    && (stat_hitm_q != '1)) stat_hitm_d = stat_hitm_q + 16'd1;
    if (rsp_timeout && (stat_tmo_q  != '1)) stat_tmo_d  = stat_tmo_q  + 16'd1;
  end

  // Counter registers
  always_ff @(posedge SCLK or posedge SRST) begin
    if (SRST) begin
      stat_hit_q  <= '0;
      stat_hitm_q <= '0;
      stat_tmo_q  <= '0;
    end else begin
      stat_hit_q  <= stat_hit_d;
      stat_hitm_q <= stat_hitm_d;
      stat_tmo_q  <= stat_tmo_d;
    end
  end

  assign stat_hit  = stat_hit_q;
  assign stat_hitm = stat_hitm_q;
  assign stat_tmo  = stat_tmo_q;
`endif

endmodule

// File: tb/tb_snoop_initiator.sv
// Bench for snoop_initiator: behavioural responder plus a result scoreboard.
module tb_snoop_initiator;
  localparam int unsigned AW = 32;

  logic SCLK = 1'b0;
  logic SRST;
  always #5 SCLK = ~SCLK;

  snoop_initiator_if #(.ADDR_W(AW)) bus ();

`ifdef SNOOP_STATS_EN
  logic [15:0] stat_hit, stat_hitm, stat_tmo;
`endif

  snoop_initiator #(.ADDR_W(AW), .TIMEOUT(16)) dut (
    .SCLK (SCLK),
    .SRST (SRST),
    .bus  (bus)
`ifdef SNOOP_STATS_EN
    ,
    .stat_hit  (stat_hit),
    .stat_hitm (stat_hitm),
    .stat_tmo  (stat_tmo)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected {hit, hitm, timeout} per accepted request
  logic [2:0] exp_q[$];

  // Responder configuration (written by the stimulus process only)
  bit cfg_respond = 1'b1;
  bit cfg_phit    = 1'b0;
  bit cfg_phitm   = 1'b0;
  bit cfg_stale   = 1'b0;
  int cfg_wb_delay = 5;

  // Per-operation observations (written by the monitor only)
  int          n_rsp = 0;
  int          sint_low_cnt, wb_high_cnt, inval_cnt;
  bit          rw_bad, saddr_bad, sint_at_rsp;
  logic [AW-1:0] cap_addr;
  logic        cap_rw;
  int          exp_hit_n = 0, exp_hitm_n = 0, exp_tmo_n = 0;

  // Monitor + responder, evaluated on the falling edge
  initial begin
    int lk_cnt, wb_cnt, inv_cnt;
    logic [2:0] e;
    lk_cnt = 0; wb_cnt = 0; inv_cnt = 0;
    bus.snoop = 1'b0; bus.PHIT = 1'b0; bus.PHITM = 1'b0; bus.PINV = 1'b0; bus.wb_done = 1'b0;
    forever begin
      @(negedge SCLK);
      if (SRST) begin exp_hit_n = 0; exp_hitm_n = 0; exp_tmo_n = 0; end
      if (bus.req_valid && bus.req_ready) begin
        cap_addr = bus.req_addr; cap_rw = bus.req_rw;
        sint_low_cnt = 0; wb_high_cnt = 0; inval_cnt = 0;
        rw_bad = 1'b0; saddr_bad = 1'b0; sint_at_rsp = 1'b0;
      end
      if (!bus.SINT) begin
        sint_low_cnt++;
        if (bus.SADDR !== cap_addr) saddr_bad = 1'b1;
      end
      if (!bus.SINT && bus.SLCK && (bus.RW !== cap_rw)) rw_bad = 1'b1;
      if (!bus.SINT && !bus.SLCK) begin
        inval_cnt++;
        if (bus.RW !== 1'b0) rw_bad = 1'b1;
      end
      if (bus.wb_req) wb_high_cnt++;
      if (bus.rsp_valid) begin
        n_rsp++;
        sint_at_rsp = bus.SINT;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("rsp_flags", {bus.rsp_hit, bus.rsp_hitm, bus.rsp_timeout}, e);
          exp_hit_n += e[2]; exp_hitm_n += e[1]; exp_tmo_n += e[0];
        end
      end
      // responder reaction to the current outputs
      lk_cnt  = (!bus.SINT && bus.SLCK && !bus.wb_req) ? lk_cnt + 1 : 0;
      wb_cnt  = bus.wb_req ? wb_cnt + 1 : 0;
      inv_cnt = (!bus.SINT && !bus.SLCK) ? inv_cnt + 1 : 0;
      bus.snoop   = cfg_respond && (lk_cnt >= 2);
      bus.PHIT    = bus.snoop ? cfg_phit  : 1'b1;
      bus.PHITM   = bus.snoop ? cfg_phitm : 1'b1;
      bus.wb_done = (wb_cnt == cfg_wb_delay);
      if (cfg_stale) bus.PINV = (inv_cnt <= 2) || (inv_cnt >= 6);
      else           bus.PINV = (inv_cnt >= 2);
    end
  end

  task automatic do_req(input logic [AW-1:0] addr, input logic rw, input logic [2:0] exp,
                        input bit wait_rsp);
    bit got;
    int start;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge SCLK); #1;
      if (bus.req_ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      check_eq("ready_wait", 64'd0, 64'd1);
      return;
    end
    bus.req_valid = 1'b1; bus.req_addr = addr; bus.req_rw = rw;
    if (wait_rsp) exp_q.push_back(exp);
    start = n_rsp;
    @(posedge SCLK); #1;
    bus.req_valid = 1'b0; bus.req_addr = ~addr; bus.req_rw = ~rw;
    if (wait_rsp) begin
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (n_rsp != start) begin got = 1'b1; break; end
        @(posedge SCLK); #1;
      end
      if (!got) check_eq("rsp_wait", 64'd0, 64'd1);
      check_eq("saddr_stable", saddr_bad, 0);
      check_eq("rw_copy", rw_bad, 0);
      check_eq("sint_high_at_rsp", sint_at_rsp, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit got;
    SRST = 1'b1;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_rw = 1'b0;
    #2;
    check_eq("reset_outs",
             {bus.SINT, bus.SLCK, bus.RW, bus.req_ready, bus.wb_req,
              bus.rsp_valid, bus.rsp_hit, bus.rsp_hitm, bus.rsp_timeout}, 9'b101_000000);
    check_eq("reset_saddr", bus.SADDR, 0);
    repeat (3) @(posedge SCLK);
    #1 SRST = 1'b0;
    @(posedge SCLK); #1;
    check_eq("ready_after_reset", bus.req_ready, 1);

    // read miss
    cfg_respond = 1; cfg_phit = 0; cfg_phitm = 0;
    do_req(32'h100, 1'b1, 3'b000, 1'b1);
    check_eq("rmiss_sint_low", sint_low_cnt, 2);
    check_eq("rmiss_wb", wb_high_cnt, 0);
    check_eq("rmiss_slck0", inval_cnt, 0);

    // read hit shared
    cfg_phit = 1; cfg_phitm = 0;
    do_req(32'h2340, 1'b1, 3'b100, 1'b1);
    check_eq("rhit_sint_low", sint_low_cnt, 2);
    check_eq("rhit_inval", inval_cnt, 0);

    // write hit modified: write-back then invalidate
    cfg_phit = 1; cfg_phitm = 1; cfg_wb_delay = 5;
    do_req(32'hABCD_0040, 1'b0, 3'b110, 1'b1);
    check_eq("whm_wb_cycles", wb_high_cnt, 5);
    check_eq("whm_inval", inval_cnt, 2);

    // write miss: invalidate only
    cfg_phit = 0; cfg_phitm = 0;
    do_req(32'h0000_0FC0, 1'b0, 3'b000, 1'b1);
    check_eq("wmiss_wb", wb_high_cnt, 0);
    check_eq("wmiss_inval", inval_cnt, 2);

    // stale PINV held high from a previous operation
    cfg_phit = 1; cfg_stale = 1;
    do_req(32'h5550, 1'b0, 3'b100, 1'b1);
    check_eq("stale_inval", inval_cnt, 6);
    cfg_stale = 0;

    // lookup timeout
    cfg_respond = 0;
    do_req(32'h7700, 1'b1, 3'b001, 1'b1);
    check_eq("tmo_lookup_cycles", sint_low_cnt, 16);
    cfg_respond = 1;

    // write-back timeout keeps captured hit/hitm
    cfg_phit = 1; cfg_phitm = 1; cfg_wb_delay = 40;
    do_req(32'h8800, 1'b1, 3'b111, 1'b1);
    check_eq("tmo_wb_cycles", wb_high_cnt, 16);
    check_eq("tmo_wb_inval", inval_cnt, 0);

    // asynchronous reset in the middle of a write-back
    cfg_wb_delay = 50;
    do_req(32'h9900, 1'b1, 3'b000, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.wb_req) begin got = 1'b1; break; end
      @(posedge SCLK); #1;
    end
    check_eq("rst_wb_reached", got, 1);
    repeat (2) @(posedge SCLK);
    #2 SRST = 1'b1;
    #1;
    check_eq("rst_mid_outs",
             {bus.SINT, bus.SLCK, bus.RW, bus.req_ready, bus.wb_req, bus.rsp_valid}, 6'b101000);
    check_eq("rst_mid_saddr", bus.SADDR, 0);
    repeat (2) @(posedge SCLK);
    #1 SRST = 1'b0;
    repeat (3) @(posedge SCLK);

    // normal operation after reset
    cfg_phit = 1; cfg_phitm = 0; cfg_wb_delay = 5;
    do_req(32'h1230, 1'b1, 3'b100, 1'b1);
    check_eq("post_rst_sint_low", sint_low_cnt, 2);
    repeat (4) @(posedge SCLK);
    check_eq("scoreboard_empty", exp_q.size(), 0);

`ifdef SNOOP_STATS_EN
    #1;
    check_eq("stat_hit", stat_hit, exp_hit_n);
    check_eq("stat_hitm", stat_hitm, exp_hitm_n);
    check_eq("stat_tmo", stat_tmo, exp_tmo_n);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
